wb_regfile: RTL and testbench
=============================

WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 SHALL have parameter DATA_W, default 32: data path and register width.
REQ-002 SHALL have parameter REG_NUM, default 32: architectural register count; address width is log2(REG_NUM) = 5.
REQ-003 SHALL have port clk_i, input, 1: single clock; all state updates on posedge.
REQ-004 SHALL have port rst_i, input, 1: one clock; reset is synchronous and active-low.
REQ-005 SHALL have port WB_i, input, 3: write-back control; bit0 = RegWrite, bits[2:1] = result select.
REQ-006 SHALL have port DM_i, input, DATA_W: load data from the WB pipeline register.
REQ-007 SHALL have port alu_ans_i, input, DATA_W: ALU result from the WB pipeline register.
REQ-008 SHALL have port WBreg_i, input, 5: destination register index.
REQ-009 SHALL have port pc_add4_i, input, DATA_W: link address for jal/jalr.
REQ-010 SHALL have ports RSaddr_i and RTaddr_i, input, 5 each: decode-stage read addresses.
REQ-011 SHALL have ports RSdata_o and RTdata_o, output, DATA_W each: read data.
REQ-012 SHALL have port wb_data_o, output, DATA_W: selected write-back value, combinational.
REQ-013 SHALL have port wb_valid_o, output, 1: high when a write to a nonzero register is committed this cycle.
REQ-014 SHALL have port retire_cnt_o, output, 32: count of committed register writes.

Function
REQ-015 SHALL select wb_data_o from WB_i[2:1]: 00 -> alu_ans_i, 01 -> DM_i, 10 -> pc_add4_i, 11 -> alu_ans_i (reserved).
REQ-016 SHALL assert wb_valid_o combinationally iff WB_i[0]=1, WBreg_i!=0, and rst_i=1.
REQ-017 SHALL write wb_data_o into register WBreg_i on the posedge where wb_valid_o=1, with 1-cycle write latency.
REQ-018 SHALL keep register 0 at 0 permanently; writes to index 0 are dropped and not counted.
REQ-019 SHALL drive read ports combinationally from the array; address 0 always reads 0.
REQ-020 SHALL bypass on same-cycle collision: when wb_valid_o=1 and a read address equals WBreg_i, that port returns wb_data_o.
REQ-021 SHALL handle RSaddr_i = RTaddr_i = WBreg_i in one cycle by bypassing both ports.
REQ-022 SHALL increment retire_cnt_o by 1 on each posedge with wb_valid_o=1, wrapping 0xFFFFFFFF -> 0.
REQ-023 SHALL ignore DM_i, alu_ans_i, pc_add4_i and WBreg_i when WB_i[0]=0, with no array change and no count.

Reset
REQ-024 SHALL clear all REG_NUM registers and retire_cnt_o to 0 on a posedge with rst_i=0.
REQ-025 SHALL give reset priority over a simultaneous write; that write is lost and not counted.
REQ-026 SHALL force wb_valid_o=0 and disable bypass while rst_i=0; read ports return 0 during reset.
REQ-027 SHALL resume normal writes on the first posedge after rst_i returns high.

Structure
REQ-028 SHALL place the WB_i bit positions, result-select encodings (SEL_ALU=00, SEL_DM=01, SEL_PC4=10) and DATA_W/REG_NUM defaults in the shared processor package.
REQ-029 SHALL keep the write-back mux inline and implement the array plus bypass as one sub-module, reg_array.
REQ-030 SHALL produce no latches, and all sequential logic SHALL be posedge clk_i only.

Verification
REQ-031 SHALL cover this case: after reset, WB_i=3'b011, DM_i=0x0000_00AB, WBreg_i=5 -> wb_data_o=0xAB, next cycle RSaddr_i=5 reads 0xAB, retire_cnt_o=1.
REQ-032 SHALL cover this case: WB_i=3'b101, pc_add4_i=0x0000_0010, WBreg_i=31, RTaddr_i=31 in the same cycle -> RTdata_o=0x10 via bypass, then 0x10 from the array.
REQ-033 SHALL cover this case: WB_i=3'b001, alu_ans_i=0xDEAD_BEEF, WBreg_i=0 -> wb_valid_o=0, RSaddr_i=0 reads 0, counter unchanged.
REQ-034 SHALL cover this case: WB_i=3'b000, alu_ans_i=0x1234, WBreg_i=7 -> register 7 unchanged and no count.
REQ-035 SHALL cover this case: rst_i=0 with a simultaneous valid write of 0x55 to register 3 -> register 3 = 0, retire_cnt_o = 0, and the write lands on the first posedge after release.
REQ-036 SHALL cover this case: force the counter to 0xFFFF_FFFF, then one valid write -> retire_cnt_o = 0.

Source files
------------

// File: rtl/wb_regfile_pkg.sv
// Shared processor definitions for the write-back stage.
// Holds the WB control bit positions, the result-select encodings and
// the default data-path / register-file sizes.
package wb_regfile_pkg;

    localparam int DATA_W_DEF  = 32;
    localparam int REG_NUM_DEF = 32;
    localparam int ADDR_W      = 5;

    // WB control word layout: bit0 = RegWrite, bits[2:1] = result select
    localparam int WB_REGWRITE = 0;
    localparam int WB_SEL_LO   = 1;
    localparam int WB_SEL_HI   = 2;

    typedef enum logic [1:0] {
        SEL_ALU = 2'b00,
        SEL_DM  = 2'b01,
        SEL_PC4 = 2'b10,
        SEL_RSV = 2'b11   // reserved, behaves as SEL_ALU
    } wb_sel_e;

endpackage

// File: rtl/wb_regfile_reg_array.sv
// Register array with two combinational read ports and write-through bypass.
// Ports:
//   clk, rst_n        - clock, synchronous active-low reset (clears array)
//   we, waddr, wdata  - write port; we must already exclude index 0
//   raddr_a/raddr_b   - read addresses
//   rdata_a/rdata_b   - read data; 0 for address 0 or while in reset,
//                       bypassed from wdata on a same-cycle address match
module reg_array
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int REG_NUM = REG_NUM_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b
);

    logic [DATA_W-1:0] regs [REG_NUM];

    // Index 0 is never written, so it stays at its reset value of 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_NUM; i++) regs[i] <= '0;
        end else if (we && waddr != '0) begin
            regs[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata_a = '0;
        if (rst_n && raddr_a != '0) begin
            if (we && raddr_a == waddr) rdata_a = wdata;
            else                        rdata_a = regs[raddr_a];
        end
    end

    always_comb begin
        rdata_b = '0;
        if (rst_n && raddr_b != '0) begin
            if (we && raddr_b == waddr) rdata_b = wdata;
            else                        rdata_b = regs[raddr_b];
        end
    end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage plus architectural register file.
// Ports:
//   clk_i, rst_i             - clock, synchronous active-low reset
//   WB_i                     - bit0 RegWrite, bits[2:1] result select
//   DM_i, alu_ans_i, pc_add4_i - candidate write-back values
//   WBreg_i                  - destination register index
//   RSaddr_i, RTaddr_i       - decode-stage read addresses
//   RSdata_o, RTdata_o       - read data (with same-cycle bypass)
//   wb_data_o                - selected write-back value
//   wb_valid_o               - a nonzero-register write commits this cycle
//   retire_cnt_o             - committed register write count (wraps)
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int REG_NUM = REG_NUM_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [2:0]        WB_i,
    input  logic [DATA_W-1:0] DM_i,
    input  logic [DATA_W-1:0] alu_ans_i,
    input  logic [ADDR_W-1:0] WBreg_i,
    input  logic [DATA_W-1:0] pc_add4_i,
    input  logic [ADDR_W-1:0] RSaddr_i,
    input  logic [ADDR_W-1:0] RTaddr_i,
    output logic [DATA_W-1:0] RSdata_o,
    output logic [DATA_W-1:0] RTdata_o,
    output logic [DATA_W-1:0] wb_data_o,
    output logic              wb_valid_o,
    output logic [31:0]       retire_cnt_o
);

    wb_sel_e     sel;
    logic [31:0] retire_cnt;

    assign sel = wb_sel_e'(WB_i[WB_SEL_HI:WB_SEL_LO]);

    always_comb begin
        unique case (sel)
            SEL_DM:  wb_data_o = DM_i;
            SEL_PC4: wb_data_o = pc_add4_i;
            default: wb_data_o = alu_ans_i;
        endcase
    end

    // Reset masks the commit so neither the array nor the counter sees it.
    assign wb_valid_o = rst_i && WB_i[WB_REGWRITE] && (WBreg_i != '0);

    reg_array #(
        .DATA_W  (DATA_W),
        .REG_NUM (REG_NUM)
    ) u_reg_array (
        .clk     (clk_i),
        .rst_n   (rst_i),
        .we      (wb_valid_o),
        .waddr   (WBreg_i),
        .wdata   (wb_data_o),
        .raddr_a (RSaddr_i),
        .raddr_b (RTaddr_i),
        .rdata_a (RSdata_o),
        .rdata_b (RTdata_o)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_i)          retire_cnt <= '0;
        else if (wb_valid_o) retire_cnt <= retire_cnt + 32'd1;
    end

    assign retire_cnt_o = retire_cnt;

endmodule

// File: tb/tb_wb_regfile.sv
module tb_wb_regfile;
    import wb_regfile_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  wb;
    logic [31:0] dm, alu, pc4;
    logic [4:0]  wreg, rsa, rta;
    logic [31:0] rsd, rtd, wbd, cnt;
    logic        wbv;

    always #5 clk = ~clk;

    wb_regfile dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .WB_i         (wb),
        .DM_i         (dm),
        .alu_ans_i    (alu),
        .WBreg_i      (wreg),
        .pc_add4_i    (pc4),
        .RSaddr_i     (rsa),
        .RTaddr_i     (rta),
        .RSdata_o     (rsd),
        .RTdata_o     (rtd),
        .wb_data_o    (wbd),
        .wb_valid_o   (wbv),
        .retire_cnt_o (cnt)
    );

    typedef struct {
        logic [31:0] wbd;
        logic        vld;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] cnt;
    } exp_t;

    exp_t        q[$];
    logic [31:0] mreg [32];
    logic [31:0] mcnt;
    int          n_chk  = 0;
    int          n_fail = 0;
    bit          done   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: value a read port must show, given this cycle's commit.
    function automatic logic [31:0] mread(input logic r, input logic v,
                                          input logic [4:0] a, input logic [31:0] d);
        if (!r || a == 0)      return 32'd0;
        if (v && a == wreg)    return d;
        return mreg[a];
    endfunction

    // Drive one cycle of inputs, queue its expected outputs, advance the model.
    task automatic apply(input logic r, input logic [2:0] w, input logic [31:0] d_dm,
                         input logic [31:0] d_alu, input logic [31:0] d_pc,
                         input logic [4:0] dst, input logic [4:0] a, input logic [4:0] b);
        exp_t        e;
        logic [31:0] val;
        logic        v;
        rst = r; wb = w; dm = d_dm; alu = d_alu; pc4 = d_pc; wreg = dst; rsa = a; rta = b;
        case (w[2:1])
            2'b01:   val = d_dm;
            2'b10:   val = d_pc;
            default: val = d_alu;
        endcase
        v     = r && w[0] && dst != 0;
        e.wbd = val;
        e.vld = v;
        e.rs  = mread(r, v, a, val);
        e.rt  = mread(r, v, b, val);
        e.cnt = mcnt;
        q.push_back(e);
        if (!r) begin
            foreach (mreg[i]) mreg[i] = 32'd0;
            mcnt = 32'd0;
        end else if (v) begin
            mreg[dst] = val;
            mcnt      = mcnt + 32'd1;
        end
    endtask

    task automatic step(input logic r, input logic [2:0] w, input logic [31:0] d_dm,
                        input logic [31:0] d_alu, input logic [31:0] d_pc,
                        input logic [4:0] dst, input logic [4:0] a, input logic [4:0] b);
        @(negedge clk);
        apply(r, w, d_dm, d_alu, d_pc, dst, a, b);
    endtask

    // Monitor: every cycle the DUT presents a response for the queued stimulus.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("wb_data", wbd, e.wbd);
                check("wb_valid", {31'd0, wbv}, {31'd0, e.vld});
                check("rs_data", rsd, e.rs);
                check("rt_data", rtd, e.rt);
                check("retire_cnt", cnt, e.cnt);
            end
        end
    end

    initial begin
        logic [4:0] d;
        rst = 0; wb = 0; dm = 0; alu = 0; pc4 = 0; wreg = 0; rsa = 0; rta = 0;
        repeat (2) @(negedge clk);
        foreach (mreg[i]) mreg[i] = 32'd0;
        mcnt = 32'd0;

        // Reset state
        step(1, 3'b000, 0, 0, 0, 0, 5'd1, 5'd31);
        // Load to r5, then read back
        step(1, 3'b011, 32'h0000_00AB, 32'h1111, 32'h2222, 5'd5, 5'd5, 5'd0);
        step(1, 3'b000, 0, 0, 0, 0, 5'd5, 5'd5);
        // Link write to r31, bypass then array
        step(1, 3'b101, 32'h3333, 32'h4444, 32'h0000_0010, 5'd31, 5'd0, 5'd31);
        step(1, 3'b000, 0, 0, 0, 0, 5'd31, 5'd31);
        // Write to r0 dropped
        step(1, 3'b001, 0, 32'hDEAD_BEEF, 0, 5'd0, 5'd0, 5'd0);
        step(1, 3'b000, 0, 0, 0, 0, 5'd0, 5'd5);
        // RegWrite low: nothing changes
        step(1, 3'b000, 0, 32'h1234, 0, 5'd7, 5'd7, 5'd7);
        step(1, 3'b000, 0, 0, 0, 0, 5'd7, 5'd7);
        // Both read ports bypass the same destination; reserved select = ALU
        step(1, 3'b111, 32'h5555, 32'hCAFE_F00D, 32'h6666, 5'd9, 5'd9, 5'd9);
        step(1, 3'b000, 0, 0, 0, 0, 5'd9, 5'd9);
        // Reset wins over a simultaneous write; write lands after release
        step(0, 3'b001, 0, 32'h55, 0, 5'd3, 5'd3, 5'd9);
        step(1, 3'b001, 0, 32'h55, 0, 5'd3, 5'd3, 5'd9);
        step(1, 3'b000, 0, 0, 0, 0, 5'd3, 5'd9);
        // Counter wrap
        @(negedge clk);
        force dut.retire_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.retire_cnt;
        mcnt = 32'hFFFF_FFFF;
        apply(1, 3'b001, 0, 32'h77, 0, 5'd12, 5'd12, 5'd0);
        step(1, 3'b000, 0, 0, 0, 0, 5'd12, 5'd0);
        step(1, 3'b001, 0, 32'h88, 0, 5'd13, 5'd0, 5'd13);
        step(1, 3'b000, 0, 0, 0, 0, 5'd13, 5'd12);

        // Randomized traffic with biased address collisions and occasional reset
        for (int i = 0; i < 400; i++) begin
            d = 5'($urandom_range(0, 31));
            step(($urandom_range(0, 19) != 0), 3'($urandom), $urandom, $urandom, $urandom, d,
                 ($urandom_range(0, 3) == 0) ? d : 5'($urandom_range(0, 31)),
                 ($urandom_range(0, 3) == 0) ? d : 5'($urandom_range(0, 31)));
        end

        repeat (3) @(negedge clk);
        #3;
        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain: got %0d pending expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        done = 1;
        $finish;
    end

endmodule
